apb_master_seq: RTL and testbench
=================================

APB_MASTER_SEQ -- requirements
Module: apb_master_seq

Interface
REQ-001 The block SHALL have one clock HCLK and a synchronous, active-low reset HRESETn, sampled only on the rising edge of HCLK.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- HCLK, in, 1: clock.
- HRESETn, in, 1: synchronous active-low reset.
- req_valid, in, 1: transfer request.
- req_ready, out, 1: request accepted this cycle when req_valid is also high.
- req_write, in, 1: 1 = write, 0 = read.
- req_addr, in, 32: transfer address.
- req_wdata, in, 32: write data.
- rsp_valid, out, 1: one-cycle completion pulse.
- rsp_err, out, 1: completion is an error; qualified by rsp_valid.
- rsp_rdata, out, 32: read data; qualified by rsp_valid.
- PSELx, out, 3: one-hot slave select.
- PENABLE, out, 1: APB access phase.
- PWRITE, out, 1: APB direction.
- PADDR, out, 32: APB address.
- PWDATA, out, 32: APB write data.
- PRDATA, in, 32: slave read data.
- PREADY, in, 1: slave ready; present only when APB_WAIT_EN is defined.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-004 A request SHALL be accepted on any rising edge where req_valid and req_ready are both 1.
- req_ready = 1 in IDLE.
- req_ready = 1 in the completing ACCESS cycle.
- req_ready = 0 otherwise.
REQ-005 Address decode SHALL be applied to bits [31:26] of req_addr at acceptance:
- 6'h20 -> PSELx = 3'b001.
- 6'h21 -> PSELx = 3'b010.
- 6'h22 -> PSELx = 3'b100.
- Any other value is unmapped.
REQ-006 For a mapped request, on acceptance:
- The registers behind PADDR, PWDATA and PWRITE SHALL load req_addr, req_wdata and req_write, and hold them stable until the next acceptance.
- The FSM SHALL go to SETUP, with PSELx set to the decoded value and PENABLE = 0.
REQ-007 SETUP SHALL last exactly one cycle, then go to ACCESS, with PENABLE = 1 and PSELx unchanged.
REQ-008 An ACCESS cycle SHALL complete when PREADY = 1 (APB_WAIT_EN defined) or unconditionally (APB_WAIT_EN undefined).
REQ-009 On completion:
- rsp_valid SHALL pulse high for exactly the next cycle, with rsp_err = 0.
- rsp_rdata SHALL equal PRDATA sampled at the completing edge for reads, and 32'd0 for writes.
REQ-010 On completion, if a new request is accepted in the same cycle, the FSM SHALL go directly to SETUP (back-to-back transfer, no IDLE cycle).
REQ-011 On completion with no new request, the FSM SHALL go to IDLE, with PSELx = 3'b000 and PENABLE = 0; PADDR, PWDATA and PWRITE SHALL hold their last values.
REQ-012 For an unmapped request:
- No APB cycle SHALL be issued, and the FSM SHALL stay in IDLE.
- rsp_valid SHALL pulse the next cycle with rsp_err = 1 and rsp_rdata = 32'd0.
- req_ready SHALL remain 1.
REQ-013 An unmapped request accepted in the completing ACCESS cycle SHALL produce its error response one cycle after the completion response, with no APB cycle issued.
REQ-014 Best-case latency from acceptance to rsp_valid SHALL be 3 cycles for a mapped request (SETUP, ACCESS, response) and 1 cycle for an unmapped request.
REQ-015 PSELx SHALL never have more than one bit set, and PENABLE SHALL never be 1 while PSELx = 3'b000.

Reset
REQ-016 When HRESETn = 0 at a rising edge, the following SHALL hold the next cycle, regardless of state:
- FSM in IDLE.
- PSELx = 3'b000, PENABLE = 0, PWRITE = 0.
- PADDR = 32'd0, PWDATA = 32'd0.
- rsp_valid = 0, rsp_err = 0, rsp_rdata = 32'd0.
- Wait counter = 0.
REQ-017 A transfer in SETUP or ACCESS when reset is asserted SHALL be abandoned with no rsp_valid pulse.
REQ-018 req_ready SHALL be 0 while HRESETn = 0.

Configuration
REQ-019 With macro APB_WAIT_EN defined:
- The PREADY port SHALL exist, and ACCESS SHALL be held while PREADY = 0.
- A 4-bit wait counter SHALL count consecutive PREADY = 0 ACCESS cycles.
- On the 16th consecutive wait cycle, the transfer SHALL be aborted: FSM to IDLE, PSELx = 0, PENABLE = 0, and rsp_valid pulses with rsp_err = 1 and rsp_rdata = 32'd0.
- req_ready SHALL be 0 in the abort cycle.
REQ-020 With APB_WAIT_EN undefined, PREADY and the wait counter SHALL be absent, and every ACCESS SHALL last exactly one cycle.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Write, addr 32'h8000_0010, data 32'hDEAD_BEEF -> SETUP cycle with PSELx = 001, PENABLE = 0; ACCESS cycle with PENABLE = 1, PWRITE = 1; rsp_valid 3 cycles after acceptance, rsp_err = 0, rsp_rdata = 0.
- Read, addr 32'h8800_0004, PRDATA = 32'h0000_0042 in ACCESS -> PSELx = 100, rsp_rdata = 32'h42.
- Two back-to-back requests, addrs 32'h8000_0000 then 32'h8400_0000 -> second SETUP immediately follows first ACCESS; PSELx goes 001 -> 010 with no zero cycle; two rsp_valid pulses 2 cycles apart.
- Unmapped addr 32'h1000_0000 -> PSELx stays 000; rsp_valid with rsp_err = 1 one cycle later.
- HRESETn = 0 during ACCESS -> all outputs at reset values the next cycle, no rsp_valid.
- APB_WAIT_EN defined: PREADY = 0 for 3 cycles then 1 -> ACCESS lasts 4 cycles, normal response; PREADY stuck at 0 -> abort after 16 wait cycles with rsp_err = 1.

Source files
------------

// File: rtl/apb_master_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_seq_if
// Purpose  : Request/response and APB bus bundle for apb_master_seq.
//            PREADY exists only when APB_WAIT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_master_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [2:0]  PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
`ifdef APB_WAIT_EN
    logic        PREADY;
`endif

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA,
`ifdef APB_WAIT_EN
        input  PREADY,
`endif
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA,
`ifdef APB_WAIT_EN
        output PREADY,
`endif
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_seq.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_seq
// Purpose  : Request-driven APB master with 3-slave address decode.
//            Optional APB_WAIT_EN adds PREADY wait states with 16-cycle abort.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_seq (
    input  wire logic        HCLK,
    input  wire logic        HRESETn,
    apb_master_seq_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    localparam logic [5:0] C_REGION0 = 6'h20;
    localparam logic [5:0] C_REGION1 = 6'h21;
    localparam logic [5:0] C_REGION2 = 6'h22;

    state_t      r_state;
    logic [2:0]  r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;
    // Error response of an unmapped request that arrived alongside a completion
    logic        r_err_pending;

    logic [2:0]  w_dec_sel;
    logic        w_mapped;
    logic        w_complete;
    logic        w_accept;

    always_comb begin
        w_dec_sel = 3'b000;
        case (bus.req_addr[31:26])
            C_REGION0: w_dec_sel = 3'b001;
            C_REGION1: w_dec_sel = 3'b010;
            C_REGION2: w_dec_sel = 3'b100;
            default:   w_dec_sel = 3'b000;
        endcase
    end

    assign w_mapped = |w_dec_sel;

`ifdef APB_WAIT_EN
    logic [3:0] r_wait_cnt;
    logic       w_abort;
    assign w_complete = (r_state == S_ACCESS) && bus.PREADY;
    assign w_abort    = (r_state == S_ACCESS) && !bus.PREADY && (r_wait_cnt == 4'hF);
`else
    assign w_complete = (r_state == S_ACCESS);
`endif

    assign bus.req_ready = HRESETn && ((r_state == S_IDLE) || w_complete);
    assign w_accept      = bus.req_valid && bus.req_ready;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state       <= S_IDLE;
            r_psel        <= 3'b000;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= 32'd0;
            r_pwdata      <= 32'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_rdata   <= 32'd0;
            r_err_pending <= 1'b0;
`ifdef APB_WAIT_EN
            r_wait_cnt    <= 4'd0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;

            if (w_accept && w_mapped) begin
                r_paddr  <= bus.req_addr;
                r_pwdata <= bus.req_wdata;
                r_pwrite <= bus.req_write;
            end

            case (r_state)
                S_IDLE: begin
                    r_err_pending <= 1'b0;
                    if (r_err_pending) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                    end
                    if (w_accept) begin
                        if (w_mapped) begin
                            r_state   <= S_SETUP;
                            r_psel    <= w_dec_sel;
                            r_penable <= 1'b0;
                        end else if (r_err_pending) begin
                            // Response slot is taken; defer by one cycle
                            r_err_pending <= 1'b1;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end
                    end
                end

                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                end

                S_ACCESS: begin
                    if (w_complete) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? 32'd0 : bus.PRDATA;
`ifdef APB_WAIT_EN
                        r_wait_cnt  <= 4'd0;
`endif
                        if (w_accept && w_mapped) begin
                            r_state   <= S_SETUP;
                            r_psel    <= w_dec_sel;
                            r_penable <= 1'b0;
                        end else begin
                            r_state       <= S_IDLE;
                            r_psel        <= 3'b000;
                            r_penable     <= 1'b0;
                            r_err_pending <= w_accept;
                        end
                    end
`ifdef APB_WAIT_EN
                    else if (w_abort) begin
                        r_state     <= S_IDLE;
                        r_psel      <= 3'b000;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_wait_cnt  <= 4'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
`endif
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_psel    <= 3'b000;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PSELx     = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_seq
// Purpose  : Randomized + directed bench for apb_master_seq against a
//            transaction-level model (acceptance -> expected APB/response).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_seq;
    logic HCLK = 1'b0;
    logic HRESETn;

    apb_master_seq_if bus ();

    apb_master_seq dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        int          cyc;
    } apb_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;

    apb_t apb_q[$];
    rsp_t rsp_q[$];
    int   cyc      = 0;
    int   last_exp = 0;
    bit   mon_en   = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    apb_t mon_a;
    rsp_t mon_r;
    int   mon_e;

    function automatic logic [31:0] slave_fn(input logic [31:0] a);
        if (a == 32'h8800_0004) return 32'h0000_0042;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [2:0] region_sel(input logic [31:0] a);
        logic [5:0] top;
        top = a[31:26];
        if (top == 6'h20) return 3'b001;
        if (top == 6'h21) return 3'b010;
        if (top == 6'h22) return 3'b100;
        return 3'b000;
    endfunction

    // Simple slave: data only meaningful in the access phase
    assign bus.PRDATA = bus.PENABLE ? slave_fn(bus.PADDR) : 32'hBAD0_BAD0;
`ifdef APB_WAIT_EN
    logic pready = 1'b1;
    assign bus.PREADY = pready;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK) begin
        if (mon_en && HRESETn) begin
            check("onehot", 32'($countones(bus.PSELx) <= 1), 32'd1);
            if (bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("spurious_rsp", 32'd1, 32'd0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check("rsp_cycle", 32'(cyc), 32'(mon_r.cyc));
                    check("rsp_err", 32'(bus.rsp_err), 32'(mon_r.err));
                    check("rsp_rdata", bus.rsp_rdata, mon_r.rdata);
                end
            end else if (rsp_q.size() != 0 && rsp_q[0].cyc <= cyc) begin
                check("rsp_missing", 32'd0, 32'd1);
                void'(rsp_q.pop_front());
            end

            if (apb_q.size() != 0 && apb_q[0].cyc == cyc) begin
                mon_a = apb_q[0];
                check("setup_psel", 32'(bus.PSELx), 32'(region_sel(mon_a.addr)));
                check("setup_penable", 32'(bus.PENABLE), 32'd0);
                check("setup_paddr", bus.PADDR, mon_a.addr);
                check("setup_pwrite", 32'(bus.PWRITE), 32'(mon_a.write));
                check("setup_pwdata", bus.PWDATA, mon_a.wdata);
            end else if (apb_q.size() != 0 && apb_q[0].cyc + 1 == cyc) begin
                mon_a = apb_q.pop_front();
                check("access_psel", 32'(bus.PSELx), 32'(region_sel(mon_a.addr)));
                check("access_penable", 32'(bus.PENABLE), 32'd1);
                check("access_paddr", bus.PADDR, mon_a.addr);
                check("access_pwrite", 32'(bus.PWRITE), 32'(mon_a.write));
            end else begin
                check("bus_idle", 32'({bus.PSELx, bus.PENABLE}), 32'd0);
            end

            if (bus.req_valid && bus.req_ready) begin
                if (region_sel(bus.req_addr) != 3'b000) begin
                    apb_q.push_back('{bus.req_addr, bus.req_wdata, bus.req_write, cyc + 1});
                    rsp_q.push_back('{1'b0, bus.req_write ? 32'd0 : slave_fn(bus.req_addr), cyc + 3});
                    last_exp = cyc + 3;
                end else begin
                    mon_e = (cyc + 1 > last_exp + 1) ? cyc + 1 : last_exp + 1;
                    rsp_q.push_back('{1'b1, 32'd0, mon_e});
                    last_exp = mon_e;
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit got;
        got           = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge HCLK);
            if (bus.req_ready) got = 1'b1;
            @(posedge HCLK);
            #1;
        end
        bus.req_valid = 1'b0;
        if (!got) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    initial begin
        logic [5:0]  top;
        logic [31:0] addr;
        int          n_acc;
        bit          got;

        HRESETn       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_psel", 32'(bus.PSELx), 32'd0);
        check("rst_penable", 32'(bus.PENABLE), 32'd0);
        check("rst_pwrite", 32'(bus.PWRITE), 32'd0);
        check("rst_paddr", bus.PADDR, 32'd0);
        check("rst_pwdata", bus.PWDATA, 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        mon_en  = 1'b1;

        issue(1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
        idle(4);
        issue(1'b0, 32'h8800_0004, 32'h1111_2222);
        idle(4);
        issue(1'b1, 32'h8000_0000, 32'hA5A5_0001);
        issue(1'b0, 32'h8400_0000, 32'h0);
        idle(5);
        issue(1'b0, 32'h1000_0000, 32'h0);
        idle(3);
        // Unmapped requests arriving right at a completion
        issue(1'b0, 32'h8400_0100, 32'h0);
        issue(1'b1, 32'hFC00_0000, 32'h5555_5555);
        issue(1'b0, 32'h0000_0000, 32'h0);
        idle(4);

        repeat (200) begin
            if ($urandom_range(0, 3) == 3) top = 6'($urandom);
            else top = 6'h20 + 6'($urandom_range(0, 2));
            addr = {top, 26'($urandom)};
            issue(1'($urandom), addr, $urandom);
            idle($urandom_range(0, 2));
        end
        idle(8);

        // Reset in the middle of an access: transfer abandoned silently
        mon_en = 1'b0;
        issue(1'b1, 32'h8800_0008, 32'h1234_5678);
        got = 1'b0;
        for (int t = 0; t < 8 && !got; t++) begin
            @(negedge HCLK);
            if (bus.PENABLE) got = 1'b1;
        end
        check("rst_reach_access", 32'(got), 32'd1);
        HRESETn = 1'b0;
        @(negedge HCLK);
        check("arst_psel", 32'(bus.PSELx), 32'd0);
        check("arst_penable", 32'(bus.PENABLE), 32'd0);
        check("arst_pwrite", 32'(bus.PWRITE), 32'd0);
        check("arst_paddr", bus.PADDR, 32'd0);
        check("arst_pwdata", bus.PWDATA, 32'd0);
        check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("arst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("arst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("arst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        repeat (4) begin
            @(negedge HCLK);
            check("arst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        apb_q.delete();
        rsp_q.delete();
        last_exp = 0;

`ifdef APB_WAIT_EN
        @(posedge HCLK);
        #1;
        pready = 1'b0;
        issue(1'b1, 32'h8000_0020, 32'hCAFE_0001);
        n_acc = 0;
        got   = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge HCLK);
            if (bus.rsp_valid) begin
                got = 1'b1;
                check("wait_rsp_err", 32'(bus.rsp_err), 32'd0);
            end else if (bus.PENABLE) begin
                n_acc++;
                if (n_acc == 4) pready = 1'b1;
            end
        end
        check("wait_rsp_seen", 32'(got), 32'd1);
        check("wait_access_len", 32'(n_acc), 32'd4);

        @(posedge HCLK);
        #1;
        pready = 1'b0;
        issue(1'b0, 32'h8400_0040, 32'h0);
        n_acc = 0;
        got   = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge HCLK);
            if (bus.rsp_valid) begin
                got = 1'b1;
                check("abort_rsp_err", 32'(bus.rsp_err), 32'd1);
                check("abort_rsp_rdata", bus.rsp_rdata, 32'd0);
                check("abort_psel", 32'({bus.PSELx, bus.PENABLE}), 32'd0);
            end else if (bus.PENABLE) begin
                n_acc++;
                if (n_acc == 16) check("abort_req_ready", 32'(bus.req_ready), 32'd0);
            end
        end
        check("abort_rsp_seen", 32'(got), 32'd1);
        check("abort_access_len", 32'(n_acc), 32'd16);
        pready = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
